pwm_ctrl_regs: RTL

Byte-wide host register bank that configures the PWM generator directly downstream of it. Holds staging registers for duty and half-period and applies them atomically on a commit write. Optionally ramps the applied duty toward the committed target in fixed steps (soft start/stop). Drives the generator's `pwmDutyl/h`, `pwmFreql/h`, `pwm_on` and `pwm_enb` inputs.

---
 rtl/pwm_ctrl_pkg.sv | 50 +++++
 rtl/pwm_ctrl_regs_tick.sv | 44 ++++
 rtl/pwm_ctrl_regs.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/pwm_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pwm_ctrl_pkg
// Shared definitions for the PWM control register bank:
//   - register addresses of the byte-wide host map
//   - CTRL bit positions
//   - ramp FSM state encoding
//   - ramp_next(): one soft-start step of the applied duty toward its target
// ---------------------------------------------------------------------------
package pwm_ctrl_pkg;

  localparam logic [2:0] ADDR_DUTY_L = 3'd0;
  localparam logic [2:0] ADDR_DUTY_H = 3'd1;
  localparam logic [2:0] ADDR_FREQ_L = 3'd2;
  localparam logic [2:0] ADDR_FREQ_H = 3'd3;
  localparam logic [2:0] ADDR_CTRL   = 3'd4;
  localparam logic [2:0] ADDR_STEP   = 3'd5;
  localparam logic [2:0] ADDR_COMMIT = 3'd6;

  localparam int CTRL_ON_BIT   = 0;
  localparam int CTRL_ENB_BIT  = 1;
  localparam int CTRL_RAMP_BIT = 2;

  localparam logic [7:0] STEP_RESET = 8'd1;

  typedef enum logic {
    IDLE = 1'b0,
    RAMP = 1'b1
  } ramp_state_e;

  // Move duty toward target by step. The difference is taken as a 17-bit
  // signed value so both directions are exact; when the remaining distance
  // is within one step the result lands exactly on target, which keeps the
  // duty from overshooting or wrapping past 0x0000 / 0xFFFF.
  function automatic logic [15:0] ramp_next(input logic [15:0] duty,
                                            input logic [15:0] target,
                                            input logic [7:0]  step);
    logic signed [16:0] diff;
    logic [16:0]        mag;
    diff = $signed({1'b0, target}) - $signed({1'b0, duty});
    mag  = diff[16] ? $unsigned(-diff) : $unsigned(diff);
    if (mag <= {9'd0, step}) begin
      return target;
    end else if (diff[16]) begin
      return duty - {8'd0, step};
    end else begin
      return duty + {8'd0, step};
    end
  endfunction

endpackage

// File: rtl/pwm_ctrl_regs_tick.sv
// ---------------------------------------------------------------------------
// pwm_ramp_tick
// Prescale counter that paces the duty ramp.
//   clk    : block clock
//   reset  : synchronous active-high reset, counter -> 0
//   clear  : force the counter to 0 (takes priority over run)
//   run    : count while high
//   tick   : high for the cycle in which count == RAMP_PRESCALE-1 and run is
//            high; the counter wraps to 0 on the following edge
// ---------------------------------------------------------------------------
module pwm_ramp_tick #(
  parameter int unsigned RAMP_PRESCALE = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic tick
);

  localparam logic [15:0] LAST = 16'(RAMP_PRESCALE - 1);

  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = (cnt_q == LAST) ? 16'd0 : cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = run && !clear && (cnt_q == LAST);

endmodule

// File: rtl/pwm_ctrl_regs.sv
// ---------------------------------------------------------------------------
// pwm_ctrl_regs
// Byte-wide host register bank for the downstream PWM generator. Duty and
// half-period are staged, then applied together on a COMMIT write. With
// ramp enabled the applied duty walks toward the committed target by STEP
// once every RAMP_PRESCALE cycles.
//   clk                 : block clock
//   reset               : synchronous active-high reset
//   wr_en/wr_addr/wr_data : single-cycle host write
//   rd_addr / rd_data   : read address sampled each cycle, registered data
//   pwm_on, pwm_enb     : CTRL bit0 / bit1
//   pwmDutyl/h          : applied duty, low/high byte
//   pwmFreql/h          : applied half-period, low/high byte
//   ramp_busy           : high while the duty ramp is in progress
// ---------------------------------------------------------------------------
module pwm_ctrl_regs
  import pwm_ctrl_pkg::*;
#(
  parameter int unsigned RAMP_PRESCALE = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [2:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic [2:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       pwm_on,
  output logic       pwm_enb,
  output logic [7:0] pwmDutyl,
  output logic [7:0] pwmDutyh,
  output logic [7:0] pwmFreql,
  output logic [7:0] pwmFreqh,
  output logic       ramp_busy
);

  // Host-visible registers
  logic [15:0] duty_stg_q;
  logic [15:0] freq_stg_q;
  logic [2:0]  ctrl_q;
  logic [7:0]  step_q;
  logic [7:0]  rd_data_q, rd_data_d;

  // Applied values and ramp state
  logic [15:0] duty_q, duty_d;
  logic [15:0] target_q, target_d;
  logic [15:0] freq_q, freq_d;
  ramp_state_e state_q, state_d;

  logic        wr_commit;
  logic        wr_ctrl;
  logic        ramp_allowed;
  logic        ctrl_drop;
  logic        tick;
  logic        tick_clear;
  logic [15:0] target_eff;
  logic [15:0] stepped;

  assign wr_commit    = wr_en && (wr_addr == ADDR_COMMIT);
  assign wr_ctrl      = wr_en && (wr_addr == ADDR_CTRL);
  assign ramp_allowed = ctrl_q[CTRL_ON_BIT] && ctrl_q[CTRL_ENB_BIT] && ctrl_q[CTRL_RAMP_BIT];
  // A CTRL write that removes any of on/enb/ramp_en aborts a running ramp.
  assign ctrl_drop    = wr_ctrl && (state_q == RAMP) &&
                        !(wr_data[CTRL_ON_BIT] && wr_data[CTRL_ENB_BIT] && wr_data[CTRL_RAMP_BIT]);

  // A commit landing on a tick edge steps toward the freshly committed target.
  assign target_eff = wr_commit ? duty_stg_q : target_q;
  assign stepped    = ramp_next(duty_q, target_eff, step_q);

  pwm_ramp_tick #(
    .RAMP_PRESCALE(RAMP_PRESCALE)
  ) u_tick (
    .clk  (clk),
    .reset(reset),
    .clear(tick_clear),
    .run  (state_q == RAMP),
    .tick (tick)
  );

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (wr_commit && ramp_allowed && (duty_stg_q != duty_q)) begin
          state_d = RAMP;
        end
      end
      RAMP: begin
        if (wr_commit && (!ramp_allowed || (duty_stg_q == duty_q))) begin
          state_d = IDLE;
        end else if (ctrl_drop) begin
          state_d = IDLE;
        end else if (tick && (stepped == target_eff)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------- FSM: outputs / datapath next values ----------------
  always_comb begin
    duty_d     = duty_q;
    target_d   = target_q;
    freq_d     = freq_q;
    tick_clear = (state_q == IDLE) && (state_d == RAMP);
    if (wr_commit) begin
      freq_d   = freq_stg_q;
      target_d = duty_stg_q;
    end
    if (wr_commit && !ramp_allowed) begin
      duty_d = duty_stg_q;
    end else if (ctrl_drop) begin
      duty_d = target_q;
    end else if ((state_q == RAMP) && tick) begin
      duty_d = stepped;
    end
  end

  // Read mux samples pre-write values, so a same-cycle write returns old data.
  always_comb begin
    rd_data_d = 8'd0;
    case (rd_addr)
      ADDR_DUTY_L: rd_data_d = duty_stg_q[7:0];
      ADDR_DUTY_H: rd_data_d = duty_stg_q[15:8];
      ADDR_FREQ_L: rd_data_d = freq_stg_q[7:0];
      ADDR_FREQ_H: rd_data_d = freq_stg_q[15:8];
      ADDR_CTRL:   rd_data_d = {5'd0, ctrl_q};
      ADDR_STEP:   rd_data_d = step_q;
      ADDR_COMMIT: rd_data_d = {6'd0, (state_q == RAMP), 1'b0};
      default:     rd_data_d = 8'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      duty_stg_q <= '0;
      freq_stg_q <= '0;
      ctrl_q     <= '0;
      step_q     <= STEP_RESET;
      duty_q     <= '0;
      target_q   <= '0;
      freq_q     <= '0;
      rd_data_q  <= '0;
    end else begin
      duty_q    <= duty_d;
      target_q  <= target_d;
      freq_q    <= freq_d;
      rd_data_q <= rd_data_d;
      if (wr_en) begin
        case (wr_addr)
          ADDR_DUTY_L: duty_stg_q[7:0]  <= wr_data;
          ADDR_DUTY_H: duty_stg_q[15:8] <= wr_data;
          ADDR_FREQ_L: freq_stg_q[7:0]  <= wr_data;
          ADDR_FREQ_H: freq_stg_q[15:8] <= wr_data;
          ADDR_CTRL:   ctrl_q           <= wr_data[2:0];
          // A zero step would stall the ramp forever, so it is stored as 1.
          ADDR_STEP:   step_q           <= (wr_data == 8'd0) ? 8'd1 : wr_data;
          default:     ;
        endcase
      end
    end
  end

  assign rd_data   = rd_data_q;
  assign pwm_on    = ctrl_q[CTRL_ON_BIT];
  assign pwm_enb   = ctrl_q[CTRL_ENB_BIT];
  assign pwmDutyl  = duty_q[7:0];
  assign pwmDutyh  = duty_q[15:8];
  assign pwmFreql  = freq_q[7:0];
  assign pwmFreqh  = freq_q[15:8];
  assign ramp_busy = (state_q == RAMP);

endmodule
